// File: rtl/decade_clock_pkg.sv
// -----------------------------------------------------------------------------
// decade_clock_pkg
// Shared types and constants for the decade clock set-mode controller.
//   set_state_t  : controller state, value is also the field_sel encoding
//   FLD_*        : bit positions of the per-field increment strobe vector
//   DEF_*        : default cycle/tick counts for a 50 MHz system clock
//   field_onehot : maps a set state to its one-hot increment strobe
// -----------------------------------------------------------------------------
package decade_clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_YEAR  = 3'd1,
        ST_SET_MONTH = 3'd2,
        ST_SET_DAY   = 3'd3,
        ST_SET_HOUR  = 3'd4,
        ST_SET_MIN   = 3'd5
    } set_state_t;

    localparam int unsigned FLD_MIN    = 0;
    localparam int unsigned FLD_HOUR   = 1;
    localparam int unsigned FLD_DAY    = 2;
    localparam int unsigned FLD_MONTH  = 3;
    localparam int unsigned FLD_YEAR   = 4;
    localparam int unsigned NUM_FIELDS = 5;

    localparam int unsigned DEF_HOLD_CYC      = 25_000_000;
    localparam int unsigned DEF_REPEAT_CYC    = 5_000_000;
    localparam int unsigned DEF_BLINK_CYC     = 12_500_000;
    localparam int unsigned DEF_TIMEOUT_TICKS = 30;

    // One-hot strobe for the field edited in a given state; RUN maps to none.
    function automatic logic [NUM_FIELDS-1:0] field_onehot(input set_state_t st);
        logic [NUM_FIELDS-1:0] oh;
        oh = 5'b00000;
        case (st)
            ST_SET_YEAR:  oh[FLD_YEAR]  = 1'b1;
            ST_SET_MONTH: oh[FLD_MONTH] = 1'b1;
            ST_SET_DAY:   oh[FLD_DAY]   = 1'b1;
            ST_SET_HOUR:  oh[FLD_HOUR]  = 1'b1;
            ST_SET_MIN:   oh[FLD_MIN]   = 1'b1;
            default:      oh            = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// -----------------------------------------------------------------------------
// btn_repeat
// Rising-edge detect with hold-to-repeat for a debounced button level.
//   clk, rst_n : clock, async active-low reset
//   btn        : debounced button level, active high
//   kill       : blocks the current cycle's pulse and every later pulse until
//                the button has been released
//   pulse      : one-cycle request (combinational); the parent registers it so
//                the press shows up on its outputs at the sampling edge
// A press gives a pulse immediately, another HOLD_CYC cycles later, then one
// every REPEAT_CYC cycles while still held.
// -----------------------------------------------------------------------------
module btn_repeat #(
    parameter int unsigned HOLD_CYC   = 25_000_000,
    parameter int unsigned REPEAT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic kill,
    output logic pulse
);

    localparam int unsigned MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic             hist_r;
    logic             blocked_r;
    logic [CNT_W-1:0] cnt_r;
    logic             edge_s;
    logic             rpt_s;

    // Edge / repeat decode; the counter only reaches zero while held after a
    // counted-down interval, because a fresh press always reloads it.
    always_comb begin
        edge_s = btn & ~hist_r;
        rpt_s  = btn & hist_r & (cnt_r == {CNT_W{1'b0}});
        pulse  = ~blocked_r & ~kill & (edge_s | rpt_s);
    end

    // History and block flag: both reset to 1 so a button held through reset
    // release neither edges nor repeats until it is let go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r    <= 1'b1;
            blocked_r <= 1'b1;
        end else begin
            hist_r <= btn;
            if (!btn) begin
                blocked_r <= 1'b0;
            end else if (kill) begin
                blocked_r <= 1'b1;
            end else begin
                blocked_r <= blocked_r;
            end
        end
    end

    // Hold/repeat down-counter: reload on each pulse, saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!btn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (pulse) begin
            cnt_r <= edge_s ? CNT_W'(HOLD_CYC - 1) : CNT_W'(REPEAT_CYC - 1);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Set-mode controller for the decade clock: steps the user through
// year/month/day/hour/minute editing, freezes the count while editing,
// issues per-field increment strobes with hold-to-repeat, blinks the edited
// field and falls back to RUN after an inactivity timeout.
//   tick       : 1 Hz single-cycle pulse from the prescaler
//   mode_btn   : debounced level, advances to the next field
//   inc_btn    : debounced level, increments the current field
//   count_en   : tick forwarded to the datapath, only in RUN
//   field_sel  : current state (0 RUN, 1 YEAR .. 5 MIN)
//   inc_strobe : one-hot increment request (0 min .. 4 year)
//   sec_clr    : seconds clear, pulsed when minute editing is confirmed
//   blink      : 1 = blank the selected field
// All outputs are registered.
// -----------------------------------------------------------------------------
module clock_set_ctrl
    import decade_clock_pkg::*;
#(
    parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
    parameter int unsigned REPEAT_CYC    = DEF_REPEAT_CYC,
    parameter int unsigned BLINK_CYC     = DEF_BLINK_CYC,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       count_en,
    output logic [2:0] field_sel,
    output logic [4:0] inc_strobe,
    output logic       sec_clr,
    output logic       blink
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_CYC + 1);

    set_state_t       state_r;
    set_state_t       succ_s;
    set_state_t       next_state_s;
    logic             mode_hist_r;
    logic             mode_edge_s;
    logic             kill_s;
    logic             inc_pulse_s;
    logic             tmo_hit_s;
    logic             state_chg_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [BLK_W-1:0] blink_cnt_r;
    logic             count_en_r;
    logic [4:0]       inc_strobe_r;
    logic             sec_clr_r;
    logic             blink_r;

    // Mode edge and the inc kill: mode edges win over inc, and RUN ignores inc
    // entirely so a press made in RUN stays dead after entering a set state.
    always_comb begin
        mode_edge_s = mode_btn & ~mode_hist_r;
        kill_s      = mode_edge_s | (state_r == ST_RUN);
    end

    btn_repeat #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_inc_repeat (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (inc_btn),
        .kill  (kill_s),
        .pulse (inc_pulse_s)
    );

    // Next-state decode: mode edge advances, otherwise a tick that completes
    // the idle count drops back to RUN (an inc strobe in that cycle rescues it).
    always_comb begin
        case (state_r)
            ST_RUN:       succ_s = ST_SET_YEAR;
            ST_SET_YEAR:  succ_s = ST_SET_MONTH;
            ST_SET_MONTH: succ_s = ST_SET_DAY;
            ST_SET_DAY:   succ_s = ST_SET_HOUR;
            ST_SET_HOUR:  succ_s = ST_SET_MIN;
            ST_SET_MIN:   succ_s = ST_RUN;
            default:      succ_s = ST_RUN;
        endcase
        tmo_hit_s = tick & (tmo_cnt_r >= TMO_W'(TIMEOUT_TICKS - 1)) & ~inc_pulse_s;
        if (mode_edge_s) begin
            next_state_s = succ_s;
        end else if ((state_r != ST_RUN) && tmo_hit_s) begin
            next_state_s = ST_RUN;
        end else begin
            next_state_s = state_r;
        end
        state_chg_s = (next_state_s != state_r);
    end

    // FSM state, mode history and the registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            mode_hist_r  <= 1'b1;
            count_en_r   <= 1'b0;
            inc_strobe_r <= 5'b00000;
            sec_clr_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            mode_hist_r  <= mode_btn;
            count_en_r   <= tick & (state_r == ST_RUN);
            inc_strobe_r <= inc_pulse_s ? field_onehot(state_r) : 5'b00000;
            sec_clr_r    <= mode_edge_s & (state_r == ST_SET_MIN);
        end
    end

    // Inactivity counter: counts ticks in a set state, cleared by any activity
    // or state change, saturates at TIMEOUT_TICKS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_RUN) || state_chg_s || mode_edge_s || inc_pulse_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (tick && (tmo_cnt_r < TMO_W'(TIMEOUT_TICKS))) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Blink phase: restarts visible on every state change and every strobe so
    // a freshly edited value is shown at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_r     <= 1'b0;
        end else if ((state_r == ST_RUN) || state_chg_s || inc_pulse_s) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_r     <= 1'b0;
        end else if (blink_cnt_r >= BLK_W'(BLINK_CYC - 1)) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLK_W'(1);
            blink_r     <= blink_r;
        end
    end

    assign count_en   = count_en_r;
    assign field_sel  = state_r;
    assign inc_strobe = inc_strobe_r;
    assign sec_clr    = sec_clr_r;
    assign blink      = blink_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Scoreboard bench for clock_set_ctrl with small cycle counts. Each driven
// cycle pushes the outputs expected after the next rising edge; a monitor pops
// and compares them one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int unsigned HOLD_CYC      = 8;
    localparam int unsigned REPEAT_CYC    = 3;
    localparam int unsigned BLINK_CYC     = 4;
    localparam int unsigned TIMEOUT_TICKS = 3;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic       count_en;
    logic [2:0] field_sel;
    logic [4:0] inc_strobe;
    logic       sec_clr;
    logic       blink;

    typedef struct packed {
        logic [2:0] fs;
        logic [4:0] st;
        logic       ce;
        logic       sc;
        logic       bc;
        logic       b;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    check_cnt;
    int    err_cnt;

    clock_set_ctrl #(
        .HOLD_CYC      (HOLD_CYC),
        .REPEAT_CYC    (REPEAT_CYC),
        .BLINK_CYC     (BLINK_CYC),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .count_en   (count_en),
        .field_sel  (field_sel),
        .inc_strobe (inc_strobe),
        .sec_clr    (sec_clr),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expectation.
    task automatic cyc(input string tag, input logic t, input logic m, input logic i,
                       input logic [2:0] fs, input logic [4:0] st, input logic ce,
                       input logic sc, input logic bc, input logic b);
        exp_t e;
        @(negedge clk);
        tick     = t;
        mode_btn = m;
        inc_btn  = i;
        e.fs = fs; e.st = st; e.ce = ce; e.sc = sc; e.bc = bc; e.b = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: compare after each rising edge against the queued expectation.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk_eq({t, "/field_sel"},  {5'd0, field_sel},  {5'd0, e.fs});
                chk_eq({t, "/inc_strobe"}, {3'd0, inc_strobe}, {3'd0, e.st});
                chk_eq({t, "/count_en"},   {7'd0, count_en},   {7'd0, e.ce});
                chk_eq({t, "/sec_clr"},    {7'd0, sec_clr},    {7'd0, e.sc});
                if (e.bc) chk_eq({t, "/blink"}, {7'd0, blink}, {7'd0, e.b});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Press and release mode once, expecting field fs afterwards.
    task automatic mode_press(input logic [2:0] fs, input logic sc);
        cyc("mode_press", 1'b0, 1'b1, 1'b0, fs, 5'b00000, 1'b0, sc, 1'b0, 1'b0);
        cyc("mode_rel",   1'b0, 1'b0, 1'b0, fs, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int         last_s;
        logic [4:0] st;
        logic [2:0] fs;
        logic       t;
        check_cnt = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        tick      = 1'b0;
        mode_btn  = 1'b0;
        inc_btn   = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst/field_sel",  {5'd0, field_sel},  8'd0);
        chk_eq("rst/inc_strobe", {3'd0, inc_strobe}, 8'd0);
        chk_eq("rst/count_en",   {7'd0, count_en},   8'd0);
        chk_eq("rst/sec_clr",    {7'd0, sec_clr},    8'd0);
        chk_eq("rst/blink",      {7'd0, blink},      8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five ticks in RUN: one count_en per tick, one cycle later.
        for (int k = 0; k < 5; k++) begin
            cyc("run_tick", 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc("run_idle", 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Six mode presses cycle through all fields; blink phase from entry.
        for (int k = 1; k <= 6; k++) begin
            fs = 3'(k % 6);
            cyc("step_press", 1'b0, 1'b1, 1'b0, fs, 5'b00000, 1'b0, (k == 6), 1'b1, 1'b0);
            for (int j = 1; j <= 9; j++) begin
                t = (j == 2);
                cyc("step_hold", t, 1'b0, 1'b0, fs, 5'b00000, t & (fs == 3'd0), 1'b0,
                    1'b1, (fs != 3'd0) & (((j / 4) % 2) == 1));
            end
        end

        // SET_HOUR: inc held 20 cycles -> strobes at +1,+9,+12,+15,+18.
        mode_press(3'd1, 1'b0);
        mode_press(3'd2, 1'b0);
        mode_press(3'd3, 1'b0);
        mode_press(3'd4, 1'b0);
        last_s = 1;
        for (int c = 1; c <= 21; c++) begin
            st = ((c == 1) || (c == 9) || (c == 12) || (c == 15) || (c == 18)) ? 5'b00010 : 5'b00000;
            if (st != 5'b00000) last_s = c;
            cyc("hour_hold", 1'b0, 1'b0, (c <= 20), 3'd4, st, 1'b0, 1'b0, 1'b1,
                (((c - last_s) / 4) % 2) == 1);
        end
        cyc("hour_blink", 1'b0, 1'b0, 1'b0, 3'd4, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1);
        mode_press(3'd5, 1'b0);
        mode_press(3'd0, 1'b1);

        // SET_DAY timeout after three idle ticks, no sec_clr.
        mode_press(3'd1, 1'b0);
        mode_press(3'd2, 1'b0);
        mode_press(3'd3, 1'b0);
        cyc("tmo_t1", 1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tmo_i1", 1'b0, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tmo_t2", 1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tmo_i2", 1'b0, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tmo_t3", 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("tmo_i3", 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Inc after tick 2 restarts the idle count: RUN only after tick 5.
        mode_press(3'd1, 1'b0);
        mode_press(3'd2, 1'b0);
        mode_press(3'd3, 1'b0);
        cyc("dly_t1",  1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_t2",  1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_inc", 1'b0, 1'b0, 1'b1, 3'd3, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_rel", 1'b0, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_t3",  1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_t4",  1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_t5",  1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dly_i5",  1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Inc held across a field change: dead until released and re-pressed.
        mode_press(3'd1, 1'b0);
        cyc("yr_inc", 1'b0, 1'b0, 1'b1, 3'd1, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("yr_hold", 1'b0, 1'b0, 1'b1, 3'd1, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("yr_hold", 1'b0, 1'b0, 1'b1, 3'd1, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("yr_mode", 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++)
            cyc("mon_held", 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mon_rel",   1'b0, 1'b0, 1'b0, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mon_inc",   1'b0, 1'b0, 1'b1, 3'd2, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mon_rel2",  1'b0, 1'b0, 1'b0, 3'd2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mode and inc edges in the same cycle: mode wins, inc stays dead.
        cyc("both_edge", 1'b0, 1'b1, 1'b1, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++)
            cyc("both_held", 1'b0, 1'b0, 1'b1, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("both_rel",  1'b0, 1'b0, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted right after a repeat strobe in SET_DAY.
        for (int c = 1; c <= 9; c++) begin
            st = ((c == 1) || (c == 9)) ? 5'b00100 : 5'b00000;
            cyc("day_rpt", 1'b0, 1'b0, 1'b1, 3'd3, st, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        mode_btn = 1'b1;
        #1;
        chk_eq("arst/field_sel",  {5'd0, field_sel},  8'd0);
        chk_eq("arst/inc_strobe", {3'd0, inc_strobe}, 8'd0);
        chk_eq("arst/count_en",   {7'd0, count_en},   8'd0);
        chk_eq("arst/sec_clr",    {7'd0, sec_clr},    8'd0);
        chk_eq("arst/blink",      {7'd0, blink},      8'd0);

        // Buttons held through reset release produce no edge.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++)
            cyc("rel_held", 1'b0, 1'b1, 1'b1, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("rel_up", 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        mode_press(3'd1, 1'b0);

        @(posedge clk);
        #2;
        chk_eq("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
